// File: rtl/fetch_ifid_stage.sv
// fetch_ifid_stage: instruction-fetch stage and IF/ID pipeline register.
// Holds the PC and runs a req/ack handshake to instruction memory.
// Honours pcwrite/if_id_write stalls and flushes on a taken branch.
// Optional build macro: FETCH_PERF_CNT_EN adds stall/flush counters.
//
// state  | meaning
// S_REQ  | request outstanding at imem_addr = pc
// S_HOLD | fetched word parked in the hold buffer while decode is stalled
module fetch_ifid_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pcwrite,
    input  logic        if_id_write,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ack,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc4,
    output logic [4:0]  if_id_rs,
    output logic [4:0]  if_id_rt,
    output logic        if_id_valid
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] stall_cycles,
    output logic [31:0] flush_count
`endif
);

    typedef enum logic {
        S_REQ  = 1'b0,
        S_HOLD = 1'b1
    } state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] target_aligned;
    logic [31:0] hold_instr;
    logic [31:0] hold_pc4;
    logic        accept;

    assign accept         = pcwrite & if_id_write;
    assign pc_plus4       = pc + 32'd4;
    assign target_aligned = branch_target & 32'hFFFF_FFFC;

    // Request is gated by rst so nothing is issued during any reset cycle.
    assign imem_req  = (state == S_REQ) && !rst;
    assign imem_addr = pc;

    assign if_id_rs = if_id_instr[25:21];
    assign if_id_rt = if_id_instr[20:16];

    // Fetch FSM, PC, hold buffer and IF/ID register.
    // The hold buffer is only meaningful while in S_HOLD.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_REQ;
            pc          <= RESET_PC;
            if_id_instr <= NOP_INSTR;
            if_id_pc4   <= 32'd0;
            if_id_valid <= 1'b0;
            hold_instr  <= NOP_INSTR;
            hold_pc4    <= 32'd0;
        end else begin
            case (state)
                S_REQ: begin
                    if (branch_taken) begin
                        pc          <= target_aligned;
                        if_id_instr <= NOP_INSTR;
                        if_id_valid <= 1'b0;
                    end else if (imem_ack) begin
                        if (accept) begin
                            if_id_instr <= imem_rdata;
                            if_id_pc4   <= pc_plus4;
                            if_id_valid <= 1'b1;
                            pc          <= pc_plus4;
                        end else begin
                            hold_instr <= imem_rdata;
                            hold_pc4   <= pc_plus4;
                            state      <= S_HOLD;
                        end
                    end else if (if_id_write) begin
                        if_id_instr <= NOP_INSTR;
                        if_id_valid <= 1'b0;
                    end
                end
                S_HOLD: begin
                    if (branch_taken) begin
                        pc          <= target_aligned;
                        if_id_instr <= NOP_INSTR;
                        if_id_valid <= 1'b0;
                        state       <= S_REQ;
                    end else if (accept) begin
                        if_id_instr <= hold_instr;
                        if_id_pc4   <= hold_pc4;
                        if_id_valid <= 1'b1;
                        pc          <= hold_pc4;
                        state       <= S_REQ;
                    end
                end
                default: state <= S_REQ;
            endcase
        end
    end

`ifdef FETCH_PERF_CNT_EN
    // Free-running performance counters; both wrap naturally at 2^32.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles <= 32'd0;
            flush_count  <= 32'd0;
        end else begin
            if (!accept)
                stall_cycles <= stall_cycles + 32'd1;
            if (branch_taken)
                flush_count <= flush_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_ifid_stage.sv
// Directed bench for fetch_ifid_stage: reset, stall/hold, wait states,
// branch flush (including from the hold state) and PC wrap.
module tb_fetch_ifid_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        pcwrite;
    logic        if_id_write;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic [31:0] imem_rdata;
    logic        imem_ack;

    logic        imem_req,    w_imem_req;
    logic [31:0] imem_addr,   w_imem_addr;
    logic [31:0] if_id_instr, w_if_id_instr;
    logic [31:0] if_id_pc4,   w_if_id_pc4;
    logic [4:0]  if_id_rs,    w_if_id_rs;
    logic [4:0]  if_id_rt,    w_if_id_rt;
    logic        if_id_valid, w_if_id_valid;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] stall_cycles, w_stall_cycles;
    logic [31:0] flush_count,  w_flush_count;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    fetch_ifid_stage u_dut (
        .clk(clk), .rst(rst), .pcwrite(pcwrite), .if_id_write(if_id_write),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .imem_ack(imem_ack),
        .if_id_instr(if_id_instr), .if_id_pc4(if_id_pc4),
        .if_id_rs(if_id_rs), .if_id_rt(if_id_rt), .if_id_valid(if_id_valid)
`ifdef FETCH_PERF_CNT_EN
        , .stall_cycles(stall_cycles), .flush_count(flush_count)
`endif
    );

    fetch_ifid_stage #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
        .clk(clk), .rst(rst), .pcwrite(pcwrite), .if_id_write(if_id_write),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .imem_req(w_imem_req), .imem_addr(w_imem_addr),
        .imem_rdata(imem_rdata), .imem_ack(imem_ack),
        .if_id_instr(w_if_id_instr), .if_id_pc4(w_if_id_pc4),
        .if_id_rs(w_if_id_rs), .if_id_rt(w_if_id_rt), .if_id_valid(w_if_id_valid)
`ifdef FETCH_PERF_CNT_EN
        , .stall_cycles(w_stall_cycles), .flush_count(w_flush_count)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_ifid(input string tag, input logic [31:0] instr, input logic [31:0] pc4,
                            input logic valid);
        chk({tag, "_instr"}, if_id_instr, instr);
        chk({tag, "_pc4"},   if_id_pc4,   pc4);
        chk({tag, "_valid"}, {31'd0, if_id_valid}, {31'd0, valid});
    endtask

    initial begin
        rst = 1'b1; pcwrite = 1'b1; if_id_write = 1'b1;
        branch_taken = 1'b0; branch_target = 32'd0;
        imem_rdata = 32'd0; imem_ack = 1'b0;

        // T1 reset
        step(); step();
        chk("rst_req",   {31'd0, imem_req}, 32'd0);
        chk("rst_valid", {31'd0, if_id_valid}, 32'd0);
        chk("rst_instr", if_id_instr, 32'd0);
        chk("rst_pc4",   if_id_pc4, 32'd0);
        rst = 1'b0;
        #1;
        chk("t1_req",  {31'd0, imem_req}, 32'd1);
        chk("t1_addr", imem_addr, 32'h0);
        imem_ack = 1'b1; imem_rdata = 32'h8C22_0004;
        step();
        chk_ifid("t1", 32'h8C22_0004, 32'h4, 1'b1);
        chk("t1_rs",   {27'd0, if_id_rs}, 32'd1);
        chk("t1_rt",   {27'd0, if_id_rt}, 32'd2);
        chk("t1_next_addr", imem_addr, 32'h4);
        // T6 wrap: the second instance fetched the same word at 0xFFFFFFFC
        chk("t6_pc4",  w_if_id_pc4, 32'h0);
        chk("t6_addr", w_imem_addr, 32'h0);
        chk("t6_valid", {31'd0, w_if_id_valid}, 32'd1);

        // T2 stall with ack at 0x4
        pcwrite = 1'b0; if_id_write = 1'b0; imem_rdata = 32'h1111_1111;
        step();
        imem_ack = 1'b0;
        chk_ifid("t2_s1", 32'h8C22_0004, 32'h4, 1'b1);
        chk("t2_s1_req",  {31'd0, imem_req}, 32'd0);
        chk("t2_s1_addr", imem_addr, 32'h4);
        step();
        chk_ifid("t2_s2", 32'h8C22_0004, 32'h4, 1'b1);
        chk("t2_s2_req",  {31'd0, imem_req}, 32'd0);
        chk("t2_s2_addr", imem_addr, 32'h4);
`ifdef FETCH_PERF_CNT_EN
        chk("t2_stall_cycles", stall_cycles, 32'd2);
`endif
        pcwrite = 1'b1; if_id_write = 1'b1;
        step();
        chk_ifid("t2_rel", 32'h1111_1111, 32'h8, 1'b1);
        chk("t2_rel_addr", imem_addr, 32'h8);
        chk("t2_rel_req",  {31'd0, imem_req}, 32'd1);

        // T3 three wait states at 0x8
        for (int i = 0; i < 3; i++) begin
            step();
            chk_ifid($sformatf("t3_w%0d", i), 32'h0, 32'h8, 1'b0);
            chk($sformatf("t3_w%0d_addr", i), imem_addr, 32'h8);
        end

        // T4 branch coincident with ack
        imem_ack = 1'b1; imem_rdata = 32'h2222_2222;
        branch_taken = 1'b1; branch_target = 32'h43;
        step();
        chk_ifid("t4_br", 32'h0, 32'h8, 1'b0);
        chk("t4_addr", imem_addr, 32'h40);
        chk("t4_req",  {31'd0, imem_req}, 32'd1);
        branch_taken = 1'b0; imem_rdata = 32'h014B_4820;
        step();
        chk_ifid("t4_fetch", 32'h014B_4820, 32'h44, 1'b1);
        chk("t4_rs", {27'd0, if_id_rs}, 32'd10);
        chk("t4_rt", {27'd0, if_id_rt}, 32'd11);
        chk("t4_next_addr", imem_addr, 32'h44);

        // T5 branch while in the hold state with if_id_write=0
        imem_rdata = 32'h3333_3333; pcwrite = 1'b0; if_id_write = 1'b0;
        step();
        chk("t5_hold_req", {31'd0, imem_req}, 32'd0);
        imem_ack = 1'b0; branch_taken = 1'b1; branch_target = 32'h40;
        step();
        chk_ifid("t5_br", 32'h0, 32'h44, 1'b0);
        chk("t5_addr", imem_addr, 32'h40);
        chk("t5_req",  {31'd0, imem_req}, 32'd1);
        branch_taken = 1'b0; pcwrite = 1'b1; if_id_write = 1'b1;
        imem_ack = 1'b1; imem_rdata = 32'h4444_4444;
        step();
        chk_ifid("t5_refetch", 32'h4444_4444, 32'h44, 1'b1);
        imem_ack = 1'b0;

`ifdef FETCH_PERF_CNT_EN
        chk("end_stall_cycles", stall_cycles, 32'd4);
        chk("end_flush_count",  flush_count,  32'd2);
`endif

        // Reset mid-handshake abandons the request and drops the request line
        rst = 1'b1;
        #1;
        chk("rst2_req_comb", {31'd0, imem_req}, 32'd0);
        step();
        chk("rst2_valid", {31'd0, if_id_valid}, 32'd0);
        chk("rst2_addr",  imem_addr, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
